// File: rtl/query_row_ingest.sv
// query_row_ingest: ingest path for query-row words crossing from wclk to rclk.
//   wclk side : gray-pointer async FIFO write port, registered wfull.
//   rclk side : first-word fall-through FIFO read, FETCH_WIDTH-word packer,
//               two-bank ping-pong row RAM with a registered read port.
// Optional feature macro: QUERY_ROW_LIVE_READ_EN
//   defined   -> reads target the bank currently being filled (live read)
//   undefined -> reads target the completed bank (pure ping-pong, default)
// Both resets are synchronous and active-low; each clears its own domain.
module query_row_ingest #(
  parameter int DSIZE       = 11,
  parameter int ASIZE       = 4,
  parameter int FETCH_WIDTH = 1,
  parameter int ADDR_WIDTH  = 7,
  parameter int DEPTH       = 128
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic                         rclk,
  input  logic                         rrst_n,
  input  logic                         winc,
  input  logic [DSIZE-1:0]             wdata,
  output logic                         wfull,
  input  logic                         fsm_enable,
  input  logic                         ren,
  input  logic [ADDR_WIDTH-1:0]        radr,
  output logic [FETCH_WIDTH*DSIZE-1:0] rdata,
  output logic                         wbank,
  output logic                         row_done
);

  localparam int FIFO_DEPTH = 1 << ASIZE;
  localparam int GW         = FETCH_WIDTH * DSIZE;
  localparam int CNT_W      = $clog2(FETCH_WIDTH + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FETCH_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Write-clock domain
  // ---------------------------------------------------------------------------
  logic [DSIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [ASIZE:0]   wbin_q, wbin_d;
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   wq1_rptr_q, wq2_rptr_q;
  logic             wfull_q, wfull_d;
  logic             wr_en;

  // Write-pointer advance and look-ahead full flag.
  // NOTE: always_comb uses blocking (=) assignments; always_ff uses non-blocking (<=).
  always_comb begin
    wr_en   = winc && !wfull_q;
    wbin_d  = wbin_q + (ASIZE + 1)'(wr_en);
    wptr_d  = (wbin_d >> 1) ^ wbin_d;
    // Full: next gray pointer equals the synced read pointer with top two bits inverted.
    wfull_d = (wptr_d == {~wq2_rptr_q[ASIZE:ASIZE-1], wq2_rptr_q[ASIZE-2:0]});
  end

  // Write-domain registers, including the read-pointer synchronizer.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      wfull_q    <= 1'b0;
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wptr_d;
      wfull_q    <= wfull_d;
      wq1_rptr_q <= rptr_q;
      wq2_rptr_q <= wq1_rptr_q;
    end
  end

  // FIFO storage write port.
  // NOTE: storage arrays carry no reset; the pointers alone define valid contents.
  always_ff @(posedge wclk) begin
    if (wr_en) fifo_mem[wbin_q[ASIZE-1:0]] <= wdata;
  end

  // ---------------------------------------------------------------------------
  // Read-clock domain
  // ---------------------------------------------------------------------------
  logic [ASIZE:0]          rbin_q, rbin_d;
  logic [ASIZE:0]          rptr_q, rptr_d;
  logic [ASIZE:0]          rq1_wptr_q, rq2_wptr_q;
  logic                    rempty_q, rempty_d;
  logic [DSIZE-1:0]        fifo_head;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [GW-1:0]           group_q, group_d;
  logic [ADDR_WIDTH-1:0]   wadr_q, wadr_d;
  logic                    wbank_q, wbank_d;
  logic                    row_done_q, row_done_d;
  logic [GW-1:0]           rdata_q, rdata_d;
  logic                    emit, deq, ram_we, rbank, radr_ok;
  int unsigned             slot;
  logic [GW-1:0]           row_mem [2][DEPTH];

`ifdef QUERY_ROW_LIVE_READ_EN
  assign rbank = wbank_q;
`else
  assign rbank = ~wbank_q;
`endif

  // Dequeue/pack/emit control, RAM write address, and read-port next state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fifo_head  = fifo_mem[rbin_q[ASIZE-1:0]];
    emit       = fsm_enable && (count_q == FULL_CNT);
    deq        = !rempty_q && fsm_enable && ((count_q != FULL_CNT) || emit);
    ram_we     = emit && rrst_n;

    rbin_d     = rbin_q + (ASIZE + 1)'(deq);
    rptr_d     = (rbin_d >> 1) ^ rbin_d;
    rempty_d   = (rptr_d == rq2_wptr_q);

    count_d    = count_q;
    group_d    = group_q;
    slot       = emit ? 0 : int'(count_q);
    if (emit)     count_d = deq ? CNT_W'(1) : '0;
    else if (deq) count_d = count_q + CNT_W'(1);
    if (deq)      group_d[slot*DSIZE +: DSIZE] = fifo_head;

    wadr_d     = wadr_q;
    wbank_d    = wbank_q;
    row_done_d = 1'b0;
    if (emit) begin
      if (wadr_q == LAST_ADR) begin
        wadr_d     = '0;
        wbank_d    = ~wbank_q;
        row_done_d = 1'b1;
      end else begin
        wadr_d     = wadr_q + ADDR_WIDTH'(1);
      end
    end

    radr_ok    = ({1'b0, radr} < DEPTH_X);
    rdata_d    = rdata_q;
    if (ren) rdata_d = radr_ok ? row_mem[rbank][radr] : '0;
  end

  // Read-domain registers, including the write-pointer synchronizer.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      count_q    <= '0;
      group_q    <= '0;
      wadr_q     <= '0;
      wbank_q    <= 1'b0;
      row_done_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      rq1_wptr_q <= wptr_q;
      rq2_wptr_q <= rq1_wptr_q;
      count_q    <= count_d;
      group_q    <= group_d;
      wadr_q     <= wadr_d;
      wbank_q    <= wbank_d;
      row_done_q <= row_done_d;
      rdata_q    <= rdata_d;
    end
  end

  // Row RAM write port; a same-edge read sees the previous contents.
  always_ff @(posedge rclk) begin
    if (ram_we) row_mem[wbank_q][wadr_q] <= group_q;
  end

  assign wfull    = wfull_q;
  assign rdata    = rdata_q;
  assign wbank    = wbank_q;
  assign row_done = row_done_q;

endmodule

// File: tb/tb_query_row_ingest.sv
// Self-checking bench for query_row_ingest (default build, FETCH_WIDTH=1).
// Accepted writes push their word to a scoreboard queue; RAM reads pop and compare.
module tb_query_row_ingest;

  localparam int DSIZE = 11;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic             wclk = 1'b0, rclk = 1'b0;
  logic             wrst_n, rrst_n;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             fsm_enable;
  logic             ren;
  logic [AW-1:0]    radr;
  logic [DSIZE-1:0] rdata;
  logic             wbank;
  logic             row_done;

  query_row_ingest #(
    .DSIZE(DSIZE), .ASIZE(4), .FETCH_WIDTH(1), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .fsm_enable(fsm_enable),
    .ren(ren), .radr(radr), .rdata(rdata), .wbank(wbank), .row_done(row_done)
  );

  always #5 wclk = ~wclk;
  always #7 rclk = ~rclk;

  int               vectors     = 0;
  int               miscompares = 0;
  int               rd_pulses   = 0;
  logic [DSIZE-1:0] exp_q [$];
  logic [DSIZE-1:0] last_exp    = '0;

  always @(negedge rclk) if (row_done === 1'b1) rd_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold both resets low for five wclk cycles.
  task automatic do_reset();
    winc   = 1'b0;
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    repeat (5) @(negedge wclk);
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    repeat (2) @(negedge rclk);
  endtask

  // Present one word, honouring wfull and optional random stalls; record it when accepted.
  task automatic write_word(input logic [DSIZE-1:0] v, input bit stalls);
    int n = 0;
    forever begin
      @(negedge wclk);
      if (n > 500) begin
        winc = 1'b0;
        check("write_timeout", 32'd1, 32'd0);
        return;
      end
      n++;
      if (wfull || (stalls && $urandom_range(0, 3) == 0)) begin
        winc = 1'b0;
      end else begin
        winc  = 1'b1;
        wdata = v;
        exp_q.push_back(v);
        return;
      end
    end
  endtask

  task automatic write_idle();
    @(negedge wclk);
    winc = 1'b0;
  endtask

  task automatic wait_wbank(input logic v);
    int n = 0;
    while (wbank !== v && n < 3000) begin
      @(negedge rclk);
      n++;
    end
    check("wbank_swap", 32'(wbank), 32'(v));
  endtask

  // Read radr=0..DEPTH-1 back-to-back and compare against the scoreboard.
  task automatic read_bank(input string tag);
    logic [DSIZE-1:0] e;
    @(negedge rclk);
    ren  = 1'b1;
    radr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge rclk);
      if (exp_q.size() == 0) begin
        check({tag, "_underflow"}, 32'd1, 32'd0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      check(tag, 32'(rdata), 32'(e));
      last_exp = e;
      if (k < DEPTH - 1) radr = AW'(k + 1);
      else               ren  = 1'b0;
    end
  endtask

  initial begin
    int p0;
    winc = 1'b0; wdata = '0; fsm_enable = 1'b0; ren = 1'b0; radr = '0;
    wrst_n = 1'b0; rrst_n = 1'b0;

    // Reset and idle.
    do_reset();
    check("rst_wfull",    32'(wfull),    32'd0);
    check("rst_rdata",    32'(rdata),    32'd0);
    check("rst_wbank",    32'(wbank),    32'd0);
    check("rst_row_done", 32'(row_done), 32'd0);

    // FIFO full with dequeue disabled: 16 words fit, the 17th is dropped.
    for (int i = 0; i < 16; i++) begin
      @(negedge wclk);
      check("fill_not_full", 32'(wfull), 32'd0);
      winc  = 1'b1;
      wdata = DSIZE'(i);
      exp_q.push_back(DSIZE'(i));
    end
    @(negedge wclk);
    check("full_after_16", 32'(wfull), 32'd1);
    wdata = 11'h7FF;                       // winc still high: 17th attempt
    @(negedge wclk);
    winc = 1'b0;
    check("full_after_17", 32'(wfull), 32'd1);
    repeat (10) @(negedge rclk);
    check("disabled_no_emit",  32'(rd_pulses), 32'd0);
    check("disabled_wbank",    32'(wbank),     32'd0);

    // Release and stream the rest of the row with random stalls.
    p0 = rd_pulses;
    fsm_enable = 1'b1;
    for (int i = 16; i < DEPTH; i++) write_word(DSIZE'(i), 1'b1);
    write_idle();
    wait_wbank(1'b1);
    repeat (3) @(negedge rclk);
    check("row_done_once", 32'(rd_pulses - p0), 32'd1);
    read_bank("bank0_row");

    // rdata holds while ren is low.
    radr = AW'(5);
    repeat (3) @(negedge rclk);
    check("ren_low_hold", 32'(rdata), 32'(last_exp));

    // Mid-stream reset: 40 words into bank 1, then flush both domains.
    for (int i = 0; i < 40; i++) write_word(DSIZE'(12'h400 + i), 1'b0);
    write_idle();
    repeat (20) @(negedge rclk);
    exp_q.delete();
    do_reset();
    check("mid_rst_wbank", 32'(wbank), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_wfull", 32'(wfull), 32'd0);

    // Fresh row must start at address 0 of bank 0.
    p0 = rd_pulses;
    for (int i = 0; i < DEPTH; i++) write_word(DSIZE'(12'h300 + i), 1'b1);
    write_idle();
    wait_wbank(1'b1);
    repeat (3) @(negedge rclk);
    check("row_done_after_rst", 32'(rd_pulses - p0), 32'd1);
    read_bank("post_rst_row");
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
